// File: rtl/mul_sequencer_if.sv
// Bus between the multiply sequencer, pipeline control and the shared ALU.
// slave  : the sequencer side (takes start/operands and the ALU result).
// master : the pipeline/ALU side.
interface mul_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             alu_sel;
  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic [4:0]       alu_FS;
  logic [WIDTH-1:0] alu_F;

  modport slave (
    input  start, op_a, op_b, alu_F,
    output busy, done, result, alu_sel, alu_A, alu_B, alu_FS
  );

  modport master (
    output start, op_a, op_b, alu_F,
    input  busy, done, result, alu_sel, alu_A, alu_B, alu_FS
  );
endinterface

// File: rtl/mul_sequencer.sv
// Multi-cycle LEGv8 MUL controller: computes the low WIDTH bits of A*B by
// borrowing the shared ALU for one add cycle and one shift cycle per
// multiplier bit. While alu_sel is high the datapath mux must route
// alu_A/alu_B/alu_FS into the ALU; otherwise the ALU belongs to the pipeline.
// Optional feature macro: MUL_EARLY_EXIT_EN -- finish as soon as the
// remaining multiplier bits are all zero instead of always running WIDTH
// iterations.
module mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input logic           clock,
  input logic           reset,
  mul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  localparam logic [4:0]       FS_ADD = 5'b01000;
  localparam logic [4:0]       FS_LSL = 5'b10000;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);
`ifdef MUL_EARLY_EXIT_EN
  localparam logic             EARLY  = 1'b1;
`else
  localparam logic             EARLY  = 1'b0;
`endif

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_r;
  logic             busy_r;
  logic             done_r;
  logic             sel_r;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_fs;
  logic [WIDTH-1:0] mplier_shr;

  assign mplier_shr = mplier >> 1;

  // Sequencer FSM; busy/done/alu_sel are registered alongside the state so
  // they describe the state being entered. result is loaded on entry to DONE
  // so it is already valid while done is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sel_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            mcand  <= bus.op_a;
            mplier <= bus.op_b;
            cnt    <= '0;
            busy_r <= 1'b1;
            // With early exit a zero multiplier never touches the ALU.
            sel_r  <= !EARLY || (bus.op_b != '0);
            state  <= ADD;
          end
        end
        ADD: begin
          if (EARLY && (mplier == '0)) begin
            result_r <= acc;
            done_r   <= 1'b1;
            sel_r    <= 1'b0;
            state    <= DONE;
          end else begin
            // Add cycle is always spent; the sum is kept only for a 1 bit.
            if (mplier[0]) acc <= bus.alu_F;
            sel_r <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          mcand  <= bus.alu_F;
          mplier <= mplier_shr;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            result_r <= acc;
            done_r   <= 1'b1;
            sel_r    <= 1'b0;
            state    <= DONE;
          end else begin
            sel_r <= !EARLY || (mplier_shr != '0);
            state <= ADD;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU operand/function drive, forced to zero whenever the ALU is released.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fs = '0;
    if (sel_r) begin
      case (state)
        ADD: begin
          alu_a  = acc;
          alu_b  = mcand;
          alu_fs = FS_ADD;
        end
        SHIFT: begin
          alu_a  = mcand;
          alu_b  = WIDTH'(1);
          alu_fs = FS_LSL;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.result  = result_r;
  assign bus.alu_sel = sel_r;
  assign bus.alu_A   = alu_a;
  assign bus.alu_B   = alu_b;
  assign bus.alu_FS  = alu_fs;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural ALU (ADD / LSL).
module tb_mul_sequencer;

  localparam int W        = 64;
  localparam int LAT_FULL = 2 * W + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(W)) bus();

  mul_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Shared ALU model: only the two functions the sequencer uses.
  assign bus.alu_F = (bus.alu_FS == 5'b01000) ? bus.alu_A + bus.alu_B :
                     (bus.alu_FS == 5'b10000) ? bus.alu_A << bus.alu_B[5:0] :
                     '0;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] a_c1, b_c1, a_c2, b_c2;
  logic [4:0]   fs_c1, fs_c2;

  function automatic int highest_k(input logic [W-1:0] b);
    int k = 0;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b);
    int k = highest_k(b);
`ifdef MUL_EARLY_EXIT_EN
    return (2 * k + 2 < LAT_FULL) ? 2 * k + 2 : LAT_FULL;
`else
    return (k >= 0) ? LAT_FULL : 0;
`endif
  endfunction

  function automatic int exp_sel(input logic [W-1:0] b);
    int k = highest_k(b);
`ifdef MUL_EARLY_EXIT_EN
    return 2 * k;
`else
    return (k >= 0) ? 2 * W : 0;
`endif
  endfunction

  // Launches one multiply from IDLE and observes it to one cycle past done.
  // Cycle 1 is the first cycle after the accepting edge. Returns with the
  // DUT back in IDLE, 1 time unit after a rising edge. done_cyc=-1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pulse_cyc, input logic [W-1:0] pa,
                        input logic [W-1:0] pb,
                        output logic [W-1:0] res, output int done_cyc,
                        output int busy_cyc, output int pulses,
                        output int sel_cyc, output logic busy1);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_cyc = -1; busy_cyc = 0; pulses = 0; sel_cyc = 0; res = '0;
    busy1 = bus.busy;
    for (int cyc = 1; cyc <= LAT_FULL + 10; cyc++) begin
      if (done_cyc > 0 && cyc > done_cyc) break;
      if (bus.busy) busy_cyc++;
      if (bus.alu_sel) sel_cyc++;
      if (cyc == 1) begin a_c1 = bus.alu_A; b_c1 = bus.alu_B; fs_c1 = bus.alu_FS; end
      if (cyc == 2) begin a_c2 = bus.alu_A; b_c2 = bus.alu_B; fs_c2 = bus.alu_FS; end
      if (bus.done) begin
        pulses++;
        if (done_cyc < 0) begin done_cyc = cyc; res = bus.result; end
      end
      if (cyc == pulse_cyc) begin
        bus.op_a = pa; bus.op_b = pb; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.alu_sel !== 1'b0) begin bad++; $display("FAIL reset_sel: got %b want 0", bus.alu_sel); end
    total++; if (bus.result !== '0) begin bad++; $display("FAIL reset_result: got %0h want 0", bus.result); end
    total++; if (bus.alu_A !== '0 || bus.alu_B !== '0) begin bad++; $display("FAIL reset_alu_ab: got %0h/%0h want 0/0", bus.alu_A, bus.alu_B); end
    total++; if (bus.alu_FS !== 5'b00000) begin bad++; $display("FAIL reset_fs: got %b want 00000", bus.alu_FS); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_basic();
    logic [W-1:0] r; int dc, bc, pc, sc; logic b1;
    run_op(64'd3, 64'd5, 0, '0, '0, r, dc, bc, pc, sc, b1);
    total++; if (r !== 64'd15) begin bad++; $display("FAIL basic_result: got %0d want 15", r); end
    total++; if (dc !== exp_lat(64'd5)) begin bad++; $display("FAIL basic_latency: got %0d want %0d", dc, exp_lat(64'd5)); end
    total++; if (bc !== exp_lat(64'd5)) begin bad++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, exp_lat(64'd5)); end
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy_cycle1: got %b want 1", b1); end
    total++; if (pc !== 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", pc); end
    total++; if (sc !== exp_sel(64'd5)) begin bad++; $display("FAIL basic_sel_cycles: got %0d want %0d", sc, exp_sel(64'd5)); end
  endtask

  task automatic test_alu_ops();
    logic [W-1:0] r; int dc, bc, pc, sc; logic b1;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, '0, '0, r, dc, bc, pc, sc, b1);
    total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL neg_result: got %0h want fffffffffffffffe", r); end
    total++; if (fs_c1 !== 5'b01000) begin bad++; $display("FAIL add_fs: got %b want 01000", fs_c1); end
    total++; if (a_c1 !== '0) begin bad++; $display("FAIL add_a: got %0h want 0", a_c1); end
    total++; if (b_c1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL add_b: got %0h want ffffffffffffffff", b_c1); end
    total++; if (fs_c2 !== 5'b10000) begin bad++; $display("FAIL shift_fs: got %b want 10000", fs_c2); end
    total++; if (b_c2 !== 64'd1) begin bad++; $display("FAIL shift_b: got %0h want 1", b_c2); end
    total++; if (a_c2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL shift_a: got %0h want ffffffffffffffff", a_c2); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] r; int dc, bc, pc, sc; logic b1;
    run_op(64'h1_0000_0000, 64'h1_0000_0000, 0, '0, '0, r, dc, bc, pc, sc, b1);
    total++; if (r !== '0) begin bad++; $display("FAIL wrap_result: got %0h want 0", r); end
    total++; if (dc !== exp_lat(64'h1_0000_0000)) begin bad++; $display("FAIL wrap_latency: got %0d want %0d", dc, exp_lat(64'h1_0000_0000)); end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] r; int dc, bc, pc, sc; logic b1;
    run_op(64'd3, 64'd5, 50, 64'd7, 64'd7, r, dc, bc, pc, sc, b1);
    total++; if (r !== 64'd15) begin bad++; $display("FAIL ignored_result: got %0d want 15", r); end
    total++; if (dc !== exp_lat(64'd5)) begin bad++; $display("FAIL ignored_latency: got %0d want %0d", dc, exp_lat(64'd5)); end
    total++; if (pc !== 1) begin bad++; $display("FAIL ignored_pulses: got %0d want 1", pc); end
    run_op(64'd7, 64'd7, 0, '0, '0, r, dc, bc, pc, sc, b1);
    total++; if (r !== 64'd49) begin bad++; $display("FAIL next_result: got %0d want 49", r); end
  endtask

  task automatic test_held_start();
    int n;
    bus.op_a = 64'd2; bus.op_b = 64'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!bus.done && n < 300) begin @(posedge clk); #1; n++; end
    total++; if (n + 1 !== exp_lat(64'd3)) begin bad++; $display("FAIL held_latency1: got %0d want %0d", n + 1, exp_lat(64'd3)); end
    total++; if (bus.result !== 64'd6) begin bad++; $display("FAIL held_result1: got %0d want 6", bus.result); end
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL held_idle_gap: got busy %b want 0", bus.busy); end
    bus.op_a = 64'd4; bus.op_b = 64'd5;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL held_reaccept: got busy %b want 1", bus.busy); end
    bus.start = 1'b0; bus.op_a = 64'd100; bus.op_b = 64'd100;
    n = 0;
    while (!bus.done && n < 300) begin @(posedge clk); #1; n++; end
    total++; if (n + 1 !== exp_lat(64'd5)) begin bad++; $display("FAIL held_latency2: got %0d want %0d", n + 1, exp_lat(64'd5)); end
    total++; if (bus.result !== 64'd20) begin bad++; $display("FAIL held_result2: got %0d want 20", bus.result); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] r; int dc, bc, pc, sc; logic b1;
    bus.op_a = 64'd9; bus.op_b = 64'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (39) begin @(posedge clk); #1; end
    total++; if (bus.busy !== (exp_lat(64'd9) >= 40)) begin bad++; $display("FAIL midrst_pre_busy: got %b want %b", bus.busy, exp_lat(64'd9) >= 40); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    total++; if (bus.alu_sel !== 1'b0) begin bad++; $display("FAIL midrst_sel: got %b want 0", bus.alu_sel); end
    total++; if (bus.result !== '0) begin bad++; $display("FAIL midrst_result: got %0h want 0", bus.result); end
    total++; if (bus.alu_FS !== 5'b00000) begin bad++; $display("FAIL midrst_fs: got %b want 00000", bus.alu_FS); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(64'd2, 64'd3, 0, '0, '0, r, dc, bc, pc, sc, b1);
    total++; if (r !== 64'd6) begin bad++; $display("FAIL midrst_new_result: got %0d want 6", r); end
    total++; if (dc !== exp_lat(64'd3)) begin bad++; $display("FAIL midrst_new_latency: got %0d want %0d", dc, exp_lat(64'd3)); end
  endtask

  task automatic test_zero();
    logic [W-1:0] r; int dc, bc, pc, sc; logic b1;
    run_op(64'd12345, 64'd0, 0, '0, '0, r, dc, bc, pc, sc, b1);
    total++; if (r !== '0) begin bad++; $display("FAIL zero_result: got %0h want 0", r); end
    total++; if (dc !== exp_lat(64'd0)) begin bad++; $display("FAIL zero_latency: got %0d want %0d", dc, exp_lat(64'd0)); end
    total++; if (sc !== exp_sel(64'd0)) begin bad++; $display("FAIL zero_sel_cycles: got %0d want %0d", sc, exp_sel(64'd0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu_ops();
    test_wrap();
    test_start_ignored();
    test_held_start();
    test_mid_reset();
    test_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
